// File: rtl/wb_if.sv
// Writeback source port: one completed instruction offered to the arbiter.
// The source drives payload and valid; the arbiter answers with ready.
interface wb_if;
    logic [4:0]  dst;
    logic [63:0] result;
    logic [63:0] pc;
    logic        wb_en;
    logic        hipri;
    logic        valid;
    logic        ready;

    modport master (
        output dst, result, pc, wb_en, hipri, valid,
        input  ready
    );

    modport slave (
        input  dst, result, pc, wb_en, hipri, valid,
        output ready
    );
endinterface

// File: rtl/wb.sv
// Writeback arbiter: hipri ip first, then round-robin ip/lsp/md,
// registered onto the register-file write port with a retire counter.
module wb #(
    parameter int unsigned INSTRET_WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    wb_if.slave                      ip_wb,
    wb_if.slave                      lsp_wb,
    wb_if.slave                      md_wb,
    output logic                     rf_wr_en_o,
    output logic [4:0]               rf_wr_id_o,
    output logic [63:0]              rf_wr_data_o,
    output logic                     wb_retire_valid_o,
    output logic [63:0]              wb_retire_pc_o,
    output logic [INSTRET_WIDTH-1:0] wb_instret_o
);

    localparam logic [1:0] SRC_IP  = 2'd0;
    localparam logic [1:0] SRC_LSP = 2'd1;
    localparam logic [1:0] SRC_MD  = 2'd2;

    localparam logic [INSTRET_WIDTH-1:0] ONE =
        {{(INSTRET_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]               rr_last_q, rr_last_d;
    logic                     rf_wr_en_q, rf_wr_en_d;
    logic [4:0]               rf_wr_id_q, rf_wr_id_d;
    logic [63:0]              rf_wr_data_q, rf_wr_data_d;
    logic                     retire_valid_q, retire_valid_d;
    logic [63:0]              retire_pc_q, retire_pc_d;
    logic [INSTRET_WIDTH-1:0] instret_q, instret_d;

    logic        hipri_req;
    logic        gnt_any;
    logic [1:0]  sel;
    logic [4:0]  sel_dst;
    logic [63:0] sel_result;
    logic [63:0] sel_pc;
    logic        sel_wb_en;

    assign hipri_req = ip_wb.valid && ip_wb.hipri;

    // Search starts at the source after rr_last and wraps around.
    always_comb begin
        gnt_any = 1'b0;
        sel     = SRC_IP;
        if (!rst) begin
            if (hipri_req) begin
                gnt_any = 1'b1;
                sel     = SRC_IP;
            end else begin
                unique case (rr_last_q)
                    SRC_IP: begin
                        if (lsp_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_LSP;
                        end else if (md_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_MD;
                        end else if (ip_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_IP;
                        end
                    end
                    SRC_LSP: begin
                        if (md_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_MD;
                        end else if (ip_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_IP;
                        end else if (lsp_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_LSP;
                        end
                    end
                    default: begin
                        if (ip_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_IP;
                        end else if (lsp_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_LSP;
                        end else if (md_wb.valid) begin
                            gnt_any = 1'b1; sel = SRC_MD;
                        end
                    end
                endcase
            end
        end
    end

    assign ip_wb.ready  = gnt_any && (sel == SRC_IP);
    assign lsp_wb.ready = gnt_any && (sel == SRC_LSP);
    assign md_wb.ready  = gnt_any && (sel == SRC_MD);

    always_comb begin
        sel_dst    = ip_wb.dst;
        sel_result = ip_wb.result;
        sel_pc     = ip_wb.pc;
        sel_wb_en  = ip_wb.wb_en;
        unique case (sel)
            SRC_LSP: begin
                sel_dst    = lsp_wb.dst;
                sel_result = lsp_wb.result;
                sel_pc     = lsp_wb.pc;
                sel_wb_en  = lsp_wb.wb_en;
            end
            SRC_MD: begin
                sel_dst    = md_wb.dst;
                sel_result = md_wb.result;
                sel_pc     = md_wb.pc;
                sel_wb_en  = md_wb.wb_en;
            end
            default: ;
        endcase
    end

    // A hipri grant must not disturb the rotation pointer.
    always_comb begin
        rr_last_d      = rr_last_q;
        rf_wr_en_d     = 1'b0;
        rf_wr_id_d     = rf_wr_id_q;
        rf_wr_data_d   = rf_wr_data_q;
        retire_valid_d = 1'b0;
        retire_pc_d    = retire_pc_q;
        instret_d      = instret_q;
        if (gnt_any) begin
            rf_wr_en_d     = sel_wb_en && (sel_dst != 5'd0);
            rf_wr_id_d     = sel_dst;
            rf_wr_data_d   = sel_result;
            retire_valid_d = 1'b1;
            retire_pc_d    = sel_pc;
            instret_d      = instret_q + ONE;
            if (!hipri_req) begin
                rr_last_d = sel;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_last_q      <= SRC_MD;
            rf_wr_en_q     <= 1'b0;
            rf_wr_id_q     <= 5'd0;
            rf_wr_data_q   <= 64'd0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= 64'd0;
            instret_q      <= '0;
        end else begin
            rr_last_q      <= rr_last_d;
            rf_wr_en_q     <= rf_wr_en_d;
            rf_wr_id_q     <= rf_wr_id_d;
            rf_wr_data_q   <= rf_wr_data_d;
            retire_valid_q <= retire_valid_d;
            retire_pc_q    <= retire_pc_d;
            instret_q      <= instret_d;
        end
    end

    assign rf_wr_en_o        = rf_wr_en_q;
    assign rf_wr_id_o        = rf_wr_id_q;
    assign rf_wr_data_o      = rf_wr_data_q;
    assign wb_retire_valid_o = retire_valid_q;
    assign wb_retire_pc_o    = retire_pc_q;
    assign wb_instret_o      = instret_q;

endmodule

// File: tb/tb_wb.sv
// Self-checking bench for wb: grant model plus writeback scoreboard,
// and a second narrow-counter instance for the wrap case.
module tb_wb;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_if ip_if ();
    wb_if lsp_if ();
    wb_if md_if ();
    wb_if n_ip_if ();
    wb_if n_lsp_if ();
    wb_if n_md_if ();

    logic        rf_wr_en;
    logic [4:0]  rf_wr_id;
    logic [63:0] rf_wr_data;
    logic        ret_valid;
    logic [63:0] ret_pc;
    logic [63:0] instret;

    logic        n_rf_wr_en;
    logic [4:0]  n_rf_wr_id;
    logic [63:0] n_rf_wr_data;
    logic        n_ret_valid;
    logic [63:0] n_ret_pc;
    logic [3:0]  n_instret;

    wb #(.INSTRET_WIDTH(64)) dut (
        .clk               (clk),
        .rst               (rst),
        .ip_wb             (ip_if),
        .lsp_wb            (lsp_if),
        .md_wb             (md_if),
        .rf_wr_en_o        (rf_wr_en),
        .rf_wr_id_o        (rf_wr_id),
        .rf_wr_data_o      (rf_wr_data),
        .wb_retire_valid_o (ret_valid),
        .wb_retire_pc_o    (ret_pc),
        .wb_instret_o      (instret)
    );

    wb #(.INSTRET_WIDTH(4)) dut_n (
        .clk               (clk),
        .rst               (rst),
        .ip_wb             (n_ip_if),
        .lsp_wb            (n_lsp_if),
        .md_wb             (n_md_if),
        .rf_wr_en_o        (n_rf_wr_en),
        .rf_wr_id_o        (n_rf_wr_id),
        .rf_wr_data_o      (n_rf_wr_data),
        .wb_retire_valid_o (n_ret_valid),
        .wb_retire_pc_o    (n_ret_pc),
        .wb_instret_o      (n_instret)
    );

    typedef struct {
        logic        en;
        logic [4:0]  id;
        logic [63:0] data;
        logic [63:0] pc;
        logic [63:0] cnt;
    } exp_t;

    exp_t sb[$];

    bit          v[3];
    logic [4:0]  d[3];
    logic [63:0] r[3];
    logic [63:0] p[3];
    bit          e[3];
    bit          hip;

    int          m_rr;
    logic [63:0] m_cnt;
    logic [4:0]  m_id;
    logic [63:0] m_data;
    int          last_gnt;

    int checks = 0;
    int failures = 0;

    task automatic apply();
        ip_if.valid   = v[0];
        ip_if.dst     = d[0];
        ip_if.result  = r[0];
        ip_if.pc      = p[0];
        ip_if.wb_en   = e[0];
        ip_if.hipri   = hip;
        lsp_if.valid  = v[1];
        lsp_if.dst    = d[1];
        lsp_if.result = r[1];
        lsp_if.pc     = p[1];
        lsp_if.wb_en  = e[1];
        lsp_if.hipri  = 1'b0;
        md_if.valid   = v[2];
        md_if.dst     = d[2];
        md_if.result  = r[2];
        md_if.pc      = p[2];
        md_if.wb_en   = e[2];
        md_if.hipri   = 1'b0;
    endtask

    function automatic int model_gnt(bit in_rst);
        if (in_rst) return -1;
        if (v[0] && hip) return 0;
        for (int k = 1; k <= 3; k++) begin
            int idx;
            idx = (m_rr + k) % 3;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: check grant, push expectation, then check registered outputs.
    task automatic cycle();
        int         g;
        bit         rst_now;
        logic [2:0] exp_rdy;
        logic [2:0] got_rdy;
        exp_t       x;
        apply();
        #1;
        rst_now = rst;
        g = model_gnt(rst_now);
        exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
        got_rdy = {md_if.ready, lsp_if.ready, ip_if.ready};
        checks++;
        if (got_rdy !== exp_rdy) begin
            failures++;
            $display("FAIL ready got=%b exp=%b t=%0t", got_rdy, exp_rdy, $time);
        end
        if (g >= 0) begin
            m_cnt = m_cnt + 64'd1;
            x.en   = e[g] && (d[g] != 5'd0);
            x.id   = d[g];
            x.data = r[g];
            x.pc   = p[g];
            x.cnt  = m_cnt;
            sb.push_back(x);
            if (!(g == 0 && hip)) m_rr = g;
        end
        last_gnt = g;
        @(posedge clk);
        #1;
        if (rst_now) begin
            sb.delete();
            m_rr = 2; m_cnt = 64'd0; m_id = 5'd0; m_data = 64'd0;
            checks++;
            if ({rf_wr_en, rf_wr_id, rf_wr_data, ret_valid, ret_pc, instret}
                !== {1'b0, 5'd0, 64'd0, 1'b0, 64'd0, 64'd0}) begin
                failures++;
                $display("FAIL reset_vals en=%b id=%0d data=%h rv=%b pc=%h cnt=%0d",
                         rf_wr_en, rf_wr_id, rf_wr_data, ret_valid, ret_pc, instret);
            end
        end else if (sb.size() > 0) begin
            x = sb.pop_front();
            m_id = x.id;
            m_data = x.data;
            checks++;
            if ({rf_wr_en, rf_wr_id, rf_wr_data} !== {x.en, x.id, x.data}) begin
                failures++;
                $display("FAIL rf_write got=%b/%0d/%h exp=%b/%0d/%h",
                         rf_wr_en, rf_wr_id, rf_wr_data, x.en, x.id, x.data);
            end
            checks++;
            if ({ret_valid, ret_pc, instret} !== {1'b1, x.pc, x.cnt}) begin
                failures++;
                $display("FAIL retire got=%b/%h/%0d exp=1/%h/%0d",
                         ret_valid, ret_pc, instret, x.pc, x.cnt);
            end
        end else begin
            checks++;
            if ({rf_wr_en, rf_wr_id, rf_wr_data, ret_valid, instret}
                !== {1'b0, m_id, m_data, 1'b0, m_cnt}) begin
                failures++;
                $display("FAIL idle got=%b/%0d/%h/%b/%0d exp=0/%0d/%h/0/%0d",
                         rf_wr_en, rf_wr_id, rf_wr_data, ret_valid, instret,
                         m_id, m_data, m_cnt);
            end
        end
        if (g >= 0 && !rst_now) begin
            r[g] = {$urandom, $urandom};
            d[g] = 5'($urandom_range(0, 31));
            p[g] = p[g] + 64'd4;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    task automatic init_srcs();
        for (int i = 0; i < 3; i++) begin
            v[i] = 1'b0;
            d[i] = 5'(i + 1);
            r[i] = 64'h100 * (i + 1);
            p[i] = 64'h1000_0000 * (i + 1);
            e[i] = 1'b1;
        end
        hip = 1'b0;
    endtask

    task automatic test_reset();
        init_srcs();
        v[0] = 1; v[1] = 1; v[2] = 1;
        m_rr = 2; m_cnt = 0; m_id = 0; m_data = 0;
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        v[0] = 0; v[1] = 0; v[2] = 0;
        cycle();
    endtask

    task automatic test_single_ip();
        init_srcs();
        do_reset();
        d[0] = 5'd5; r[0] = 64'h1234; e[0] = 1; p[0] = 64'h8000_0000;
        v[0] = 1;
        cycle();
        v[0] = 0;
        checks++;
        if ({last_gnt, rf_wr_en, rf_wr_id, rf_wr_data, ret_pc, instret}
            !== {32'sd0, 1'b1, 5'd5, 64'h1234, 64'h8000_0000, 64'd1}) begin
            failures++;
            $display("FAIL single_ip gnt=%0d en=%b id=%0d data=%h pc=%h cnt=%0d",
                     last_gnt, rf_wr_en, rf_wr_id, rf_wr_data, ret_pc, instret);
        end
        cycle();
    endtask

    task automatic test_rotation();
        init_srcs();
        do_reset();
        v[0] = 1; v[1] = 1; v[2] = 1;
        for (int i = 0; i < 6; i++) begin
            cycle();
            checks++;
            if (last_gnt != i % 3) begin
                failures++;
                $display("FAIL rotation step=%0d got=%0d exp=%0d", i, last_gnt, i % 3);
            end
        end
        checks++;
        if (instret !== 64'd6) begin
            failures++;
            $display("FAIL rotation_count got=%0d exp=6", instret);
        end
        v[0] = 0; v[1] = 0; v[2] = 0;
        cycle();
        cycle();
    endtask

    task automatic test_hipri();
        int exp_seq[3] = '{0, 1, 2};
        init_srcs();
        do_reset();
        v[0] = 1;
        cycle();
        v[0] = 1; v[1] = 1; v[2] = 1; hip = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            v[0] = 0; hip = 0;
            checks++;
            if (last_gnt != exp_seq[i]) begin
                failures++;
                $display("FAIL hipri step=%0d got=%0d exp=%0d", i, last_gnt, exp_seq[i]);
            end
            if (i == 1) v[1] = 0;
        end
        v[2] = 0;
        cycle();
    endtask

    task automatic test_x0_noen();
        logic [63:0] base;
        init_srcs();
        do_reset();
        base = instret;
        v[2] = 1; d[2] = 5'd0; e[2] = 1; r[2] = 64'hdead;
        cycle();
        v[2] = 0;
        checks++;
        if ({rf_wr_en, ret_valid} !== 2'b01) begin
            failures++;
            $display("FAIL x0_write en=%b rv=%b exp en=0 rv=1", rf_wr_en, ret_valid);
        end
        v[1] = 1; d[1] = 5'd7; e[1] = 0;
        cycle();
        v[1] = 0;
        checks++;
        if ({rf_wr_en, ret_valid} !== 2'b01) begin
            failures++;
            $display("FAIL no_wb_en en=%b rv=%b exp en=0 rv=1", rf_wr_en, ret_valid);
        end
        checks++;
        if (instret !== base + 64'd2) begin
            failures++;
            $display("FAIL x0_count got=%0d exp=%0d", instret, base + 64'd2);
        end
        cycle();
    endtask

    task automatic test_reset_mid();
        init_srcs();
        do_reset();
        v[0] = 1; v[1] = 1; v[2] = 1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        cycle();
        checks++;
        if (last_gnt != 0) begin
            failures++;
            $display("FAIL reset_mid_first got=%0d exp=0", last_gnt);
        end
        v[0] = 0; v[1] = 0; v[2] = 0;
        cycle();
    endtask

    // Random traffic that respects the hold rule: only granted or idle sources change.
    task automatic test_random();
        init_srcs();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            cycle();
            for (int s = 0; s < 3; s++) begin
                if (last_gnt == s || !v[s]) begin
                    v[s] = ($urandom_range(0, 3) != 0);
                    e[s] = ($urandom_range(0, 4) != 0);
                end
            end
            if (last_gnt == 0 || !v[0]) hip = ($urandom_range(0, 3) == 0);
        end
        v[0] = 0; v[1] = 0; v[2] = 0; hip = 0;
        cycle();
    endtask

    task automatic test_wrap();
        logic [3:0] exp_cnt;
        init_srcs();
        do_reset();
        n_ip_if.valid = 1'b1;
        for (int i = 0; i < 17; i++) begin
            n_ip_if.pc = 64'(i * 4);
            #1;
            checks++;
            if (n_ip_if.ready !== 1'b1) begin
                failures++;
                $display("FAIL wrap_ready step=%0d got=%b exp=1", i, n_ip_if.ready);
            end
            @(posedge clk);
            #1;
            exp_cnt = 4'(i + 1);
            checks++;
            if (n_instret !== exp_cnt) begin
                failures++;
                $display("FAIL wrap_count step=%0d got=%0d exp=%0d", i, n_instret, exp_cnt);
            end
        end
        n_ip_if.valid = 1'b0;
        checks++;
        if (n_instret !== 4'd1) begin
            failures++;
            $display("FAIL wrap_final got=%0d exp=1", n_instret);
        end
    endtask

    initial begin
        n_ip_if.valid = 0; n_ip_if.hipri = 0; n_ip_if.wb_en = 1;
        n_ip_if.dst = 5'd3; n_ip_if.result = 64'h55; n_ip_if.pc = 64'd0;
        n_lsp_if.valid = 0; n_lsp_if.hipri = 0; n_lsp_if.wb_en = 0;
        n_lsp_if.dst = 5'd0; n_lsp_if.result = 64'd0; n_lsp_if.pc = 64'd0;
        n_md_if.valid = 0; n_md_if.hipri = 0; n_md_if.wb_en = 0;
        n_md_if.dst = 5'd0; n_md_if.result = 64'd0; n_md_if.pc = 64'd0;
        test_reset();
        test_single_ip();
        test_rotation();
        test_hipri();
        test_x0_noen();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb.md
# wb

Writeback arbiter for the RISu64 core. It sits downstream of the integer pipeline (`ip`), the load/store pipeline (`lsp`) and the multiply/divide pipeline (`md`). Each cycle it grants at most one of them, registers the selected result onto the single register-file write port, and counts retired instructions. Branch results from `ip` (flagged hipri) always win, so redirects and register writes stay ordered. The other grants rotate round-robin so that no source is starved.

## Interface
- `INSTRET_WIDTH`, 64: width of the retired-instruction counter.
- `clk`  in  1  clock.
- `rst`  in  1  reset, synchronous, active-high.
- `ip_wb_dst` / `lsp_wb_dst` / `md_wb_dst`  in  5 each  destination register.
- `ip_wb_result` / `lsp_wb_result` / `md_wb_result`  in  64 each  result data.
- `ip_wb_pc` / `lsp_wb_pc` / `md_wb_pc`  in  64 each  PC of the instruction.
- `ip_wb_wb_en` / `lsp_wb_wb_en` / `md_wb_wb_en`  in  1 each  instruction writes the register file.
- `ip_wb_hipri`  in  1  the `ip` entry must be granted ahead of the other sources.
- `ip_wb_valid` / `lsp_wb_valid` / `md_wb_valid`  in  1 each  source holds a completed instruction.
- `ip_wb_ready` / `lsp_wb_ready` / `md_wb_ready`  out  1 each  grant; the transfer completes when valid && ready.
- `rf_wr_en`  out  1  register-file write strobe.
- `rf_wr_id`  out  5  write register index.
- `rf_wr_data`  out  64  write data.
- `wb_retire_valid`  out  1  one instruction retired in the previous cycle.
- `wb_retire_pc`  out  64  PC of that instruction.
- `wb_instret`  out  INSTRET_WIDTH  running count of retired instructions.

## Operation
- Source encoding: IP=0, LSP=1, MD=2. State `rr_last` (2 bits) holds the last non-hipri grant.
- Grant selection (combinational), in priority order:
  - When rst is high, no source is granted.
  - If `ip_wb_valid && ip_wb_hipri`, IP is granted.
  - Otherwise the grant is the first valid source after `rr_last`, in circular order IP→LSP→MD→IP.
- Ready outputs: exactly the granted source sees ready=1. All ready outputs are 0 when no source is valid.
- Ready never depends on any ready input, so there is no combinational loop. It depends only on the valid/hipri inputs and `rr_last`.
- `rr_last` update:
  - It takes the granted source id only on a non-hipri grant.
  - A hipri grant leaves it unchanged.
  - An idle cycle leaves it unchanged.
- Register-file write: on a grant, `rf_wr_en <= wb_en && (dst != 0)`, `rf_wr_id <= dst`, `rf_wr_data <= result`. Without a grant, `rf_wr_en <= 0`; id and data hold their previous values.
- Writes to x0 are never issued, but the instruction still retires.
- Retire:
  - On a grant, `wb_retire_valid <= 1` and `wb_retire_pc <= pc`. Otherwise `wb_retire_valid <= 0`.
  - `wb_instret` increments by 1 per grant and wraps modulo 2^INSTRET_WIDTH.
  - Retirement is counted even when wb_en=0 (branches, stores).
- Starvation: continuous hipri traffic starves LSP and MD. This is accepted, because `ip` can only assert hipri every cycle if branches are back-to-back.

## Timing
- Grant and ready: same cycle as valid (0-cycle combinational).
- Register-file write and retire outputs: 1 cycle after the grant (registered).
- Throughput: one retirement per cycle.
- Data-hold rule: a source whose valid is not granted must keep its valid and payload stable. `wb` does not buffer unaccepted entries.
- Reset values:
  - `rf_wr_en`=0, `rf_wr_id`=0, `rf_wr_data`=0.
  - `wb_retire_valid`=0, `wb_retire_pc`=0, `wb_instret`=0.
  - `rr_last`=MD, so IP has first round-robin priority.
- Reset mid-operation:
  - In the cycle rst is asserted, all ready outputs are 0 and no write occurs.
  - Registered outputs take their reset values at the next edge.
  - An entry presented during reset is not consumed.
- Simultaneous events:
  - With all three valid and no hipri, grants rotate IP, LSP, MD on successive cycles, provided each source stays valid.
  - If hipri arrives mid-rotation, IP is granted and the rotation resumes where it left off.
- Counter wrap: with INSTRET_WIDTH=4, the count goes 15→0 on the 16th retirement and no other flag is raised.

## Test plan
- Reset, then a single `ip` entry (dst=5, result=0x1234, wb_en=1, pc=0x8000_0000) → `ip_wb_ready`=1 that cycle. Next cycle: `rf_wr_en`=1, id=5, data=0x1234, `wb_retire_pc`=0x8000_0000, `wb_instret`=1.
- All three sources held valid for 6 cycles, no hipri → grant order IP, LSP, MD, IP, LSP, MD, and `wb_instret`=6.
- LSP and MD valid, with `rr_last`=IP; then `ip` valid with hipri=1 → IP granted first. LSP is granted next, then MD, so the pointer is unaffected by the hipri grant.
- `md` entry with dst=0 and wb_en=1, then `lsp` entry with wb_en=0 → `rf_wr_en`=0 in both result cycles, `wb_retire_valid`=1 both times, `wb_instret` +2.
- rst asserted while all sources are valid → all ready outputs 0. Next cycle: all outputs at reset values. After release, IP is granted first.
- INSTRET_WIDTH=4 with 17 single-source retirements → `wb_instret` reads 1 after the 17th.
